// File: rtl/cu_de_hazard_stage.sv
// Decode->Execute control register with load-use hazard detection, bubble insertion and freeze.
// Optional bubble statistics counters are enabled by defining STALL_STATS_EN.
module cu_de_hazard_stage #(
  parameter int REG_ADDR_W = 5,
  parameter int ALUCTRL_W  = 3,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteD,
  input  logic [1:0]            ResultSrcD,
  input  logic                  MemWriteD,
  input  logic                  JumpD,
  input  logic                  BranchD,
  input  logic [ALUCTRL_W-1:0]  ALUControlD,
  input  logic                  ALUSrcD,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] RdD,
  input  logic                  ValidD,
  input  logic                  ExtStall,
  input  logic                  PCSrcE,
  output logic                  RegWriteE,
  output logic [1:0]            ResultSrcE,
  output logic                  MemWriteE,
  output logic                  JumpE,
  output logic                  BranchE,
  output logic [ALUCTRL_W-1:0]  ALUControlE,
  output logic                  ALUSrcE,
  output logic [REG_ADDR_W-1:0] Rs1E,
  output logic [REG_ADDR_W-1:0] Rs2E,
  output logic [REG_ADDR_W-1:0] RdE,
  output logic                  ValidE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  FlushD,
  output logic [CNT_W-1:0]      LwBubbleCnt,
  output logic [CNT_W-1:0]      FlushBubbleCnt
);

  localparam logic [1:0] RESULT_LOAD = 2'b01;

  logic lwStall;
  logic insertBubble;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign lwStall = ValidE & ValidD & (ResultSrcE == RESULT_LOAD) & (RdE != '0) &
                   ((RdE == Rs1D) | (RdE == Rs2D));
  assign StallF       = lwStall | ExtStall;
  assign StallD       = lwStall | ExtStall;
  assign FlushD       = PCSrcE & ~ExtStall;
  assign insertBubble = PCSrcE | lwStall;

  always_ff @(posedge clk) begin
    if (rst) begin
      RegWriteE   <= 1'b0;
      ResultSrcE  <= '0;
      MemWriteE   <= 1'b0;
      JumpE       <= 1'b0;
      BranchE     <= 1'b0;
      ALUControlE <= '0;
      ALUSrcE     <= 1'b0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
      ValidE      <= 1'b0;
    end else if (!ExtStall) begin
      // A frozen pipeline keeps E untouched; hazards are re-evaluated once it thaws.
      if (insertBubble) begin
        RegWriteE   <= 1'b0;
        ResultSrcE  <= '0;
        MemWriteE   <= 1'b0;
        JumpE       <= 1'b0;
        BranchE     <= 1'b0;
        ALUControlE <= '0;
        ALUSrcE     <= 1'b0;
        Rs1E        <= '0;
        Rs2E        <= '0;
        RdE         <= '0;
        ValidE      <= 1'b0;
      end else begin
        RegWriteE   <= RegWriteD;
        ResultSrcE  <= ResultSrcD;
        MemWriteE   <= MemWriteD;
        JumpE       <= JumpD;
        BranchE     <= BranchD;
        ALUControlE <= ALUControlD;
        ALUSrcE     <= ALUSrcD;
        Rs1E        <= Rs1D;
        Rs2E        <= Rs2D;
        RdE         <= RdD;
        ValidE      <= ValidD;
      end
    end
  end

`ifdef STALL_STATS_EN
  logic [CNT_W-1:0] lwBubbleCntReg;
  logic [CNT_W-1:0] flushBubbleCntReg;

  // A bubble caused by a taken branch is attributed to the flush, even if a load-use coincides.
  always_ff @(posedge clk) begin
    if (rst) begin
      lwBubbleCntReg    <= '0;
      flushBubbleCntReg <= '0;
    end else if (!ExtStall) begin
      if (PCSrcE) begin
        flushBubbleCntReg <= flushBubbleCntReg + 1'b1;
      end else if (lwStall) begin
        lwBubbleCntReg <= lwBubbleCntReg + 1'b1;
      end
    end
  end

  assign LwBubbleCnt    = lwBubbleCntReg;
  assign FlushBubbleCnt = flushBubbleCntReg;
`else
  assign LwBubbleCnt    = '0;
  assign FlushBubbleCnt = '0;
`endif

endmodule

// File: tb/tb_cu_de_hazard_stage.sv
// Directed + short random bench for cu_de_hazard_stage; expected E state is queued when driven
// and popped after the clock edge. Counter expectations follow STALL_STATS_EN.
module tb_cu_de_hazard_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ValidD, ExtStall, PCSrcE;
  logic [1:0]  ResultSrcD;
  logic [2:0]  ALUControlD;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ValidE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic        StallF, StallD, FlushD;
  logic [31:0] LwBubbleCnt, FlushBubbleCnt;

  typedef struct packed {
    logic       regWrite;
    logic [1:0] resultSrc;
    logic       memWrite;
    logic       jump;
    logic       branch;
    logic [2:0] aluCtrl;
    logic       aluSrc;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       valid;
  } eState_t;

  typedef struct packed {
    eState_t     e;
    logic [31:0] lwCnt;
    logic [31:0] flCnt;
  } eRec_t;

  eRec_t       sbQ[$];
  eState_t     model;
  logic [31:0] modelLw, modelFl;
  bit          modelKnown = 1'b0;
  int          compCnt = 0;
  int          failCnt = 0;

  always #5 clk = ~clk;

  cu_de_hazard_stage #(.REG_ADDR_W(5), .ALUCTRL_W(3), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD),
    .JumpD(JumpD), .BranchD(BranchD), .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ValidD(ValidD),
    .ExtStall(ExtStall), .PCSrcE(PCSrcE),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ValidE(ValidE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .LwBubbleCnt(LwBubbleCnt), .FlushBubbleCnt(FlushBubbleCnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compCnt++;
    assert (obs === exp) else begin
      failCnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic setD(input logic v, input logic rw, input logic [1:0] rs, input logic mw,
                      input logic j, input logic b, input logic [2:0] alu, input logic as,
                      input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
    ValidD = v; RegWriteD = rw; ResultSrcD = rs; MemWriteD = mw; JumpD = j; BranchD = b;
    ALUControlD = alu; ALUSrcD = as; Rs1D = r1; Rs2D = r2; RdD = rd;
  endtask

  // One clock: check hazard outputs, queue expected E state, clock, then pop and compare.
  task automatic step(input string tag);
    eRec_t   r;
    eState_t obs;
    logic    lw;
    #1;
    lw = 1'b0;
    if (modelKnown) begin
      lw = model.valid & ValidD & (model.resultSrc == 2'b01) & (model.rd != 5'd0) &
           ((model.rd == Rs1D) | (model.rd == Rs2D));
      chk({tag, ".StallF"}, 64'(StallF), 64'(lw | ExtStall));
      chk({tag, ".StallD"}, 64'(StallD), 64'(lw | ExtStall));
      chk({tag, ".FlushD"}, 64'(FlushD), 64'(PCSrcE & ~ExtStall));
    end
    if (rst) begin
      model = '0; modelLw = '0; modelFl = '0; modelKnown = 1'b1;
    end else if (!ExtStall) begin
      if (PCSrcE | lw) begin
`ifdef STALL_STATS_EN
        if (PCSrcE) modelFl = modelFl + 1; else modelLw = modelLw + 1;
`endif
        model = '0;
      end else begin
        model = '{RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUControlD, ALUSrcD,
                  Rs1D, Rs2D, RdD, ValidD};
      end
    end
    r.e = model; r.lwCnt = modelLw; r.flCnt = modelFl;
    sbQ.push_back(r);
    @(posedge clk);
    #1;
    r   = sbQ.pop_front();
    obs = {RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE,
           Rs1E, Rs2E, RdE, ValidE};
    chk({tag, ".E"}, 64'(obs), 64'(r.e));
    chk({tag, ".LwCnt"}, 64'(LwBubbleCnt), 64'(r.lwCnt));
    chk({tag, ".FlCnt"}, 64'(FlushBubbleCnt), 64'(r.flCnt));
    $display("step %-10s E=%h ValidE=%0d RdE=%0d Lw=%0d Fl=%0d", tag, obs, ValidE, RdE,
             LwBubbleCnt, FlushBubbleCnt);
  endtask

  initial begin
    rst = 1'b1; ExtStall = 1'b0; PCSrcE = 1'b0;
    @(posedge clk); #1;
    // Reset with nonzero D inputs.
    setD(1, 1, 2'b01, 1, 1, 1, 3'b111, 1, 5'd7, 5'd7, 5'd9);
    step("rst0");
    step("rst1");
    chk("rst.ValidE", 64'(ValidE), 64'(1'b0));
    chk("rst.StallF", 64'(StallF), 64'(1'b0));
    chk("rst.FlushD", 64'(FlushD), 64'(1'b0));

    // Pass-through.
    rst = 1'b0;
    setD(1, 1, 2'b00, 0, 0, 0, 3'b010, 0, 5'd1, 5'd2, 5'd5);
    step("pass");
    chk("pass.RdE", 64'(RdE), 64'd5);
    chk("pass.ALUControlE", 64'(ALUControlE), 64'(3'b010));
    chk("pass.ValidE", 64'(ValidE), 64'(1'b1));

    // Load-use on Rs2.
    setD(1, 1, 2'b01, 0, 0, 0, 3'b000, 1, 5'd3, 5'd4, 5'd7);
    step("ld7");
    setD(1, 1, 2'b00, 0, 0, 0, 3'b001, 0, 5'd8, 5'd7, 5'd10);
    #1; chk("lu.StallF", 64'(StallF), 64'(1'b1));
    step("lu_stall");
    chk("lu.bubValidE", 64'(ValidE), 64'(1'b0));
    chk("lu.bubRegWrE", 64'(RegWriteE), 64'(1'b0));
    step("lu_go");
    chk("lu.RdE", 64'(RdE), 64'd10);

    // Load to x0 never stalls.
    setD(1, 1, 2'b01, 0, 0, 0, 3'b000, 1, 5'd3, 5'd4, 5'd0);
    step("ldx0");
    setD(1, 1, 2'b00, 0, 0, 0, 3'b000, 0, 5'd0, 5'd0, 5'd11);
    step("x0_use");
    chk("x0.RdE", 64'(RdE), 64'd11);

    // Branch flush.
    setD(1, 0, 2'b00, 1, 0, 1, 3'b011, 0, 5'd2, 5'd3, 5'd0);
    step("pre_br");
    PCSrcE = 1'b1;
    step("flush");
    chk("flush.MemWriteE", 64'(MemWriteE), 64'(1'b0));
    PCSrcE = 1'b0;

    // External stall overriding a flush, then flush once it releases.
    setD(1, 1, 2'b10, 1, 1, 0, 3'b101, 1, 5'd12, 5'd13, 5'd14);
    step("pre_ext");
    ExtStall = 1'b1; PCSrcE = 1'b1;
    setD(1, 1, 2'b00, 0, 0, 0, 3'b110, 0, 5'd15, 5'd16, 5'd17);
    for (int i = 0; i < 3; i++) step("ext_hold");
    chk("ext.RdE", 64'(RdE), 64'd14);
    ExtStall = 1'b0;
    step("ext_flush");
    PCSrcE = 1'b0;

    // External stall during a load-use, then the hazard resolves.
    setD(1, 1, 2'b01, 0, 0, 0, 3'b000, 1, 5'd1, 5'd1, 5'd20);
    step("ld20");
    setD(1, 0, 2'b00, 1, 0, 0, 3'b000, 1, 5'd20, 5'd2, 5'd0);
    ExtStall = 1'b1;
    step("ext_lu");
    ExtStall = 1'b0;
    step("lu2_stall");
    step("lu2_go");

    // Reset mid-stall leaves no stale stall.
    setD(1, 1, 2'b01, 0, 0, 0, 3'b000, 1, 5'd1, 5'd1, 5'd21);
    step("ld21");
    setD(1, 1, 2'b00, 0, 0, 0, 3'b100, 0, 5'd21, 5'd0, 5'd22);
    rst = 1'b1;
    step("rst_mid");
    rst = 1'b0;
    step("post_rst");
    chk("post_rst.RdE", 64'(RdE), 64'd22);

    // Invalid D slot: fields registered, ValidE low, and it raises no hazard.
    setD(1, 1, 2'b01, 0, 0, 0, 3'b000, 1, 5'd1, 5'd1, 5'd3);
    step("ld3");
    setD(0, 1, 2'b00, 1, 0, 0, 3'b010, 0, 5'd3, 5'd3, 5'd6);
    step("invalidD");
    chk("invalid.ValidE", 64'(ValidE), 64'(1'b0));
    chk("invalid.RegWriteE", 64'(RegWriteE), 64'(1'b1));

    // Random mix with a small register range to provoke hazards.
    for (int i = 0; i < 60; i++) begin
      setD(1'($urandom_range(0, 3) != 0), 1'($urandom), 2'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), 3'($urandom), 1'($urandom),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      ExtStall = ($urandom_range(0, 4) == 0);
      PCSrcE   = ($urandom_range(0, 4) == 0);
      step("rand");
    end

    chk("sb.empty", 64'(sbQ.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCnt, failCnt);
    $finish;
  end

endmodule
